// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neuron datapath: activation encoding,
// popcount saturation and accumulator sizing.
package tnn_pkg;

    typedef logic [1:0] act_t;

    localparam act_t ACT_POS  = 2'b01;
    localparam act_t ACT_ZERO = 2'b00;
    localparam act_t ACT_NEG  = 2'b11;

    localparam int POP_MAX = 8;

    // Popcounts come from 8-input units, so anything above 8 is saturated.
    function automatic logic [3:0] popcnt_clamp(input logic [31:0] cnt);
        logic [3:0] res;
        res = (cnt > 32'(POP_MAX)) ? 4'(POP_MAX) : cnt[3:0];
        return res;
    endfunction

    // Signed width that holds +/-8*max_chunks without wrapping.
    function automatic int acc_width(input int max_chunks);
        return $clog2(POP_MAX * max_chunks + 1) + 1;
    endfunction

endpackage

// File: rtl/ternary_threshold.sv
// Combinational ternary activation: compares a signed sum against an upper and
// a lower threshold; the upper threshold wins when the two overlap.
module ternary_threshold
    import tnn_pkg::*;
#(
    parameter int ACC_W = 9
) (
    input  logic [ACC_W-1:0] sum_i,
    input  logic [ACC_W-1:0] th_hi_i,
    input  logic [ACC_W-1:0] th_lo_i,
    output act_t             act_o
);

    always_comb begin
        act_o = ACT_ZERO;
        if ($signed(sum_i) >= $signed(th_hi_i)) begin
            act_o = ACT_POS;
        end else if ($signed(sum_i) <= $signed(th_lo_i)) begin
            act_o = ACT_NEG;
        end
    end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulates (pos - neg) popcount differences over the chunks of one neuron,
// then holds the thresholded ternary result until the consumer takes it.
module ternary_neuron_acc
    import tnn_pkg::*;
#(
    parameter int MAX_CHUNKS = 16,
    parameter int CNT_W      = 4,
    parameter int ACC_W      = acc_width(MAX_CHUNKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [CNT_W-1:0] pos_cnt,
    input  logic [CNT_W-1:0] neg_cnt,
    input  logic [ACC_W-1:0] th_hi,
    input  logic [ACC_W-1:0] th_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       act,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int CHK_W = $clog2(MAX_CHUNKS + 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CHK_W-1:0] chk_q,   chk_d;
    logic [ACC_W-1:0] sum_q,   sum_d;
    act_t             act_q,   act_d;
    logic             ovf_q,   ovf_d;

    logic [3:0]       pos_c;
    logic [3:0]       neg_c;
    logic [ACC_W-1:0] diff;
    logic [ACC_W-1:0] total;
    act_t             total_act;
    logic             accept;
    logic             forced;

    assign pos_c = popcnt_clamp(32'(pos_cnt));
    assign neg_c = popcnt_clamp(32'(neg_cnt));

    // Zero-extend both clamped counts first so the subtraction yields the
    // correctly sign-extended difference in ACC_W bits.
    assign diff  = ACC_W'(pos_c) - ACC_W'(neg_c);
    assign total = acc_q + diff;

    assign accept = in_valid && (state_q == ST_ACC);
    assign forced = (chk_q == CHK_W'(MAX_CHUNKS - 1));

    ternary_threshold #(
        .ACC_W (ACC_W)
    ) u_threshold (
        .sum_i   (total),
        .th_hi_i (th_hi),
        .th_lo_i (th_lo),
        .act_o   (total_act)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        chk_d   = chk_q;
        sum_d   = sum_q;
        act_d   = act_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (in_last || forced) begin
                        sum_d   = total;
                        act_d   = total_act;
                        ovf_d   = forced && !in_last;
                        acc_d   = '0;
                        chk_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        acc_d = total;
                        chk_d = chk_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            chk_q   <= '0;
            sum_q   <= '0;
            act_q   <= ACT_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
            ovf_q   <= ovf_d;
        end
    end

    // Both handshake flags are pure functions of the registered state.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign act       = act_q;
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Scoreboard bench for ternary_neuron_acc: the driver models each neuron and
// queues its expected result; the monitor pops and compares on each handshake.
module tb_ternary_neuron_acc;

    localparam int ACC_W = 9;
    localparam int MAXC  = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [3:0]       pos_cnt;
    logic [3:0]       neg_cnt;
    logic [ACC_W-1:0] th_hi;
    logic [ACC_W-1:0] th_lo;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       act;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    typedef struct {
        int s;
        int a;
        int o;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   m_acc  = 0;
    int   m_cnt  = 0;
    int   th_hi_v = 0;
    int   th_lo_v = 0;

    assign th_hi = th_hi_v[ACC_W-1:0];
    assign th_lo = th_lo_v[ACC_W-1:0];

    ternary_neuron_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .pos_cnt   (pos_cnt),
        .neg_cnt   (neg_cnt),
        .th_hi     (th_hi),
        .th_lo     (th_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act       (act),
        .sum       (sum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_act(input int s, input int hi, input int lo);
        if (s >= hi) return 1;
        if (s <= lo) return 3;
        return 0;
    endfunction

    function automatic int ssum();
        return int'($signed(sum));
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int p, input int n, input bit last);
        int g;
        int pc;
        int nc;
        g        = 0;
        pos_cnt  = p[3:0];
        neg_cnt  = n[3:0];
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check_val("accept_timeout", g, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        pc = (p > 8) ? 8 : p;
        nc = (n > 8) ? 8 : n;
        m_acc += pc - nc;
        m_cnt++;
        if (last || m_cnt == MAXC) begin
            q.push_back('{m_acc, model_act(m_acc, th_hi_v, th_lo_v), last ? 0 : 1});
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            check_val("pending_exp", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check_val("sum", ssum(), e.s);
                check_val("act", int'(act), e.a);
                check_val("ovf", int'(ovf), e.o);
                $display("txn %0d: sum=%0d act=%b ovf=%0d (exp sum=%0d act=%0d ovf=%0d)",
                         txn, ssum(), act, ovf, e.s, e.a, e.o);
                txn++;
            end
        end
    end

    initial begin
        int g;
        int len;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        pos_cnt   = '0;
        neg_cnt   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_act", int'(act), 0);
        check_val("rst_sum", ssum(), 0);
        check_val("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single chunk, one-cycle latency.
        th_hi_v = 2; th_lo_v = -2;
        send(5, 2, 1);
        check_val("t1_valid", int'(out_valid), 1);
        check_val("t1_sum", ssum(), 3);
        @(negedge clk);
        check_val("t1_ready_back", int'(in_ready), 1);

        // Three chunks held under backpressure.
        th_hi_v = 4; th_lo_v = -4;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        send(1, 4, 0);
        send(0, 8, 0);
        send(3, 3, 1);
        check_val("t2_sum", ssum(), -11);
        check_val("t2_act", int'(act), 3);
        pos_cnt = 4'd7; neg_cnt = 4'd0; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_in_ready", int'(in_ready), 0);
            check_val("bp_out_valid", int'(out_valid), 1);
            check_val("bp_sum", ssum(), -11);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        send(7, 0, 1);
        check_val("t3_sum", ssum(), 7);

        // Forced close after MAX_CHUNKS chunks.
        @(negedge clk);
        for (int i = 0; i < MAXC; i++) send(8, 0, 0);
        check_val("ovf_flag", int'(ovf), 1);
        check_val("ovf_sum", ssum(), 128);
        send(1, 0, 1);
        check_val("ovf_next_sum", ssum(), 1);
        check_val("ovf_next_flag", int'(ovf), 0);

        // Clamping and overlapping thresholds.
        @(negedge clk);
        th_hi_v = 8; th_lo_v = -8;
        send(15, 0, 1);
        check_val("clamp_sum", ssum(), 8);
        check_val("clamp_act", int'(act), 1);
        @(negedge clk);
        th_hi_v = 9; th_lo_v = 9;
        send(15, 0, 1);
        check_val("clamp_lo_act", int'(act), 3);
        @(negedge clk);
        th_hi_v = 2; th_lo_v = -2;
        send(0, 12, 1);
        check_val("clamp_neg_sum", ssum(), -8);
        @(negedge clk);
        send(4, 4, 0);
        send(0, 0, 1);
        check_val("zero_act", int'(act), 0);

        // Reset mid-neuron.
        @(negedge clk);
        th_hi_v = 4; th_lo_v = -4;
        send(1, 0, 0);
        send(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", int'(out_valid), 0);
        check_val("arst_in_ready", int'(in_ready), 1);
        m_acc = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(2, 0, 1);
        check_val("arst_sum", ssum(), 2);

        // Reset during HOLD discards the pending result.
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        send(3, 0, 1);
        check_val("hold_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("hrst_out_valid", int'(out_valid), 0);
        check_val("hrst_in_ready", int'(in_ready), 1);
        check_val("hrst_sum", ssum(), 0);
        q.delete();
        m_acc = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);

        // Random neurons.
        for (int i = 0; i < 12; i++) begin
            th_hi_v = int'($urandom_range(0, 20)) - 10;
            th_lo_v = int'($urandom_range(0, 20)) - 10;
            len     = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), j == len - 1);
            end
            @(negedge clk);
        end

        g = 0;
        while (q.size() > 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_val("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
